pc_stack_10: RTL
================

Name: pc_stack_10

Overview:
Program-counter register and hardware return-address stack for the 10-bit instruction address path. Consumes the selected next-PC from the 4:1 next-address mux and registers it as the architectural PC. Produces PC+1 and the top-of-stack return address, which feed back into that mux's inputs. Push and pop are driven by the control unit on call and return instructions.

Parameters:
AW, 10, address width (PC, stack entries)
DEPTH, 8, return-address stack entries
PW, 4, stack-pointer width; must hold 0..DEPTH inclusive

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
next_pc  input  AW  selected next address from next-PC mux
pc_write  input  1  load next_pc into pc this edge; 0 = stall/hold
push  input  1  call: push pc_plus1 onto stack
pop  input  1  return: discard top entry
pc  output  AW  registered program counter
pc_plus1  output  AW  combinational pc+1, modulo 2^AW
ra_top  output  AW  combinational top-of-stack entry; 0 when empty
stack_count  output  PW  registered number of valid entries, 0..DEPTH
stack_empty  output  1  stack_count == 0
stack_full  output  1  stack_count == DEPTH
stack_err  output  1  sticky overflow/underflow flag

Behaviour:
- One clock; reset is synchronous and active-high; all state updates on rising clk edge.
- Reset (overrides all inputs in that cycle): pc=0, stack_count=0, stack_err=0. Stack RAM contents are not cleared. After reset: pc_plus1=1, ra_top=0, stack_empty=1, stack_full=0.
- Reset mid-operation: any push/pop/pc_write in the reset cycle is discarded.
- PC:
  - pc_write=1: pc <= next_pc, visible one cycle later.
  - pc_write=0: pc holds.
  - pc_plus1 = pc + 1, truncated to AW bits, so 1023 -> 0. No carry-out.
- Stack pointer: stack_count is the pointer. Entry i is valid for i < stack_count. Top is entry stack_count-1.
- Push only (push=1, pop=0):
  - Not full: entry[stack_count] <= pc_plus1 (pre-edge value); stack_count++.
  - Full: push ignored, contents unchanged, stack_err <= 1.
- Pop only (push=0, pop=1):
  - Not empty: stack_count--.
  - Empty: ignored, stack_err <= 1.
- Push and pop in the same cycle (tail call):
  - Not empty: entry[stack_count-1] <= pc_plus1; stack_count unchanged.
  - Empty: behaves as push only; no error.
- push/pop are independent of pc_write and may coincide with a PC load. Pushed value is always pc_plus1 of the current (pre-edge) pc.
- ra_top is combinational from the registered pointer and RAM. During a pop cycle it shows the entry being popped, so the mux can select it as next_pc in the same cycle.
- stack_err stays 1 until reset.
- Outputs are never X after reset: ra_top is forced to 0 when empty, and unwritten entries are never exposed.

Decomposition:
- Shared package:
  - ADDR_W=10, RAS_DEPTH=8 constants.
  - Reset vector constant PC_RESET=0.
  - Next-PC select encodings, shared with the mux: 0=PC+1, 1=branch, 2=jump, 3=return.
- One natural sub-module: ras_lifo (storage array, pointer, full/empty/err logic). The PC register stays in the top module.

Test Plan:
- Reset, then pc_write=1 with next_pc=0x005 for 3 cycles -> pc=0x005; pc_plus1=0x006; ra_top=0; stack_empty=1; stack_err=0.
- pc=0x3FF -> pc_plus1=0x000. Hold pc_write=0 for 4 cycles -> pc stays 0x3FF.
- At pc=0x010, push and load next_pc=0x200; then at pc=0x200, push -> count=2, ra_top=0x201. Pop -> ra_top=0x011, count=1.
- 8 pushes from pc=0x000..0x007 -> stack_full=1. A 9th push -> count stays 8, ra_top=0x008, stack_err=1. Err persists until reset.
- Pop on empty stack -> count=0, stack_err=1. Simultaneous push+pop on empty at pc=0x0A0 -> count=1, ra_top=0x0A1.
- count=3 with top=0x100; simultaneous push+pop at pc=0x0F0 -> count=3, ra_top=0x0F1. Assert reset with push=1 -> count=0, pc=0, stack_err=0.

Source files
------------

// File: rtl/pc_stack_10_pkg.sv
// Shared constants and encodings for the 10-bit PC / return-address stack
// and the next-PC mux that feeds it.
package pc_stack_10_pkg;

  localparam int ADDR_W    = 10;
  localparam int RAS_DEPTH = 8;
  localparam int PTR_W     = 4;   // holds 0..RAS_DEPTH inclusive

  localparam logic [ADDR_W-1:0] PC_RESET = '0;

  // Select encodings of the 4:1 next-PC mux in front of this block.
  typedef enum logic [1:0] {
    NEXT_PC_PLUS1 = 2'd0,
    NEXT_BRANCH   = 2'd1,
    NEXT_JUMP     = 2'd2,
    NEXT_RETURN   = 2'd3
  } next_sel_e;

endpackage

// File: rtl/pc_stack_10_if.sv
// Control/mux-side bundle of the PC and return-address stack; the control
// unit and next-PC mux take the master side, pc_stack_10 the slave side.
interface pc_stack_10_if
  import pc_stack_10_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int PW = PTR_W
);

  logic [AW-1:0] next_pc;
  logic          pc_write;
  logic          push;
  logic          pop;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus1;
  logic [AW-1:0] ra_top;
  logic [PW-1:0] stack_count;
  logic          stack_empty;
  logic          stack_full;
  logic          stack_err;

  modport master (
    output next_pc, pc_write, push, pop,
    input  pc, pc_plus1, ra_top, stack_count, stack_empty, stack_full, stack_err
  );

  modport slave (
    input  next_pc, pc_write, push, pop,
    output pc, pc_plus1, ra_top, stack_count, stack_empty, stack_full, stack_err
  );

endinterface

// File: rtl/pc_stack_10_ras_lifo.sv
// Return-address LIFO: storage array, pointer, full/empty and sticky error.
// A simultaneous push+pop replaces the top entry (tail call).
module ras_lifo
  import pc_stack_10_pkg::*;
#(
  parameter int AW    = ADDR_W,
  parameter int DEPTH = RAS_DEPTH,
  parameter int PW    = PTR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top_data,
  output logic [PW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          err
);

  localparam int IW = $clog2(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [PW-1:0] count_m1;
  logic [IW-1:0] top_idx;

  assign empty    = (count_q == '0);
  assign full     = (count_q == PW'(DEPTH));
  assign count_m1 = count_q - PW'(1);
  assign top_idx  = count_m1[IW-1:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    count_d = count_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_idx  = count_q[IW-1:0];
    case ({push, pop})
      2'b10: begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + PW'(1);
        end
      end
      2'b01: begin
        if (empty) err_d   = 1'b1;
        else       count_d = count_m1;
      end
      2'b11: begin
        wr_en = 1'b1;
        if (empty) count_d = PW'(1);    // nothing to replace: plain push
        else       wr_idx  = top_idx;
      end
      default: ;
    endcase
    // A reset cycle discards the push along with everything else.
    if (reset) wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array is deliberately not reset; entries at or above the
  // pointer are never exposed, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_data;
  end

  assign top_data = empty ? '0 : mem_q[top_idx];
  assign count    = count_q;
  assign err      = err_q;

endmodule

// File: rtl/pc_stack_10.sv
// Architectural PC register plus hardware return-address stack. Returns
// PC+1 and the stack top combinationally to the next-PC mux.
module pc_stack_10
  import pc_stack_10_pkg::*;
#(
  parameter int AW    = ADDR_W,
  parameter int DEPTH = RAS_DEPTH,
  parameter int PW    = PTR_W
) (
  input  logic          clk,
  input  logic          reset,
  pc_stack_10_if.slave  bus
);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc_plus1;

  always_comb begin
    pc_d = pc_q;
    if (bus.pc_write) pc_d = bus.next_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= AW'(PC_RESET);
    else       pc_q <= pc_d;
  end

  // Wraps modulo 2^AW; there is no carry-out.
  assign pc_plus1 = pc_q + AW'(1);

  ras_lifo #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.push),
    .pop       (bus.pop),
    .push_data (pc_plus1),
    .top_data  (bus.ra_top),
    .count     (bus.stack_count),
    .empty     (bus.stack_empty),
    .full      (bus.stack_full),
    .err       (bus.stack_err)
  );

  assign bus.pc       = pc_q;
  assign bus.pc_plus1 = pc_plus1;

endmodule
